// File: rtl/fetch_realign_buf_pkg.sv
// Shared types and constants for the realigning fetch buffer.
// Optional compressed-instruction support is selected by the CVA6_CEXT_EN macro
// in the files that import this package.
package fetch_realign_buf_pkg;

   localparam int FETCH_XLEN        = 32;
   localparam int FETCH_HW_PER_WORD = 2;

   typedef struct packed {
      logic [FETCH_XLEN-1:0] data;
      logic [FETCH_XLEN-1:0] addr;
   } fetch_req_t;

   typedef struct packed {
      logic [FETCH_XLEN-1:0] instr;
      logic [FETCH_XLEN-1:0] pc;
      logic                  is_compressed;
   } realign_instr_t;

   // A halfword starts a 16-bit instruction unless its two low bits are both set.
   function automatic logic hw_is_compressed(input logic [1:0] low_bits);
      return low_bits != 2'b11;
   endfunction

endpackage

// File: rtl/realign_hw_fifo.sv
// Halfword ring buffer: push 0/1/2 halfwords, pop 0/1/2 halfwords, and peek
// at the two oldest slots. Pointers wrap naturally because HW_DEPTH is a power of two.
module realign_hw_fifo
   import fetch_realign_buf_pkg::*;
#(
   parameter int HW_DEPTH = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic [1:0]                 push_cnt_i,
   input  logic [15:0]                push_hw0_i,
   input  logic [15:0]                push_hw1_i,
   input  logic [1:0]                 pop_cnt_i,
   output logic [$clog2(HW_DEPTH):0]  count_o,
   output logic [15:0]                peek0_o,
   output logic [15:0]                peek1_o
);

   localparam int PTR_W = $clog2(HW_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [15:0]      mem_q [HW_DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] head_p1;
   logic [PTR_W-1:0] tail_p1;

   assign head_p1 = head_q + PTR_W'(1);
   assign tail_p1 = tail_q + PTR_W'(1);

   // Pointer and occupancy next-state; flush empties the ring in one cycle.
   always_comb begin
      head_d  = head_q + PTR_W'(pop_cnt_i);
      tail_d  = tail_q + PTR_W'(push_cnt_i);
      count_d = count_q + CNT_W'(push_cnt_i) - CNT_W'(pop_cnt_i);
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   // Control state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Slot storage; contents past the count are don't-care, so no reset.
   always_ff @(posedge clk_i) begin
      if (!flush_i && (push_cnt_i != 2'd0)) begin
         mem_q[tail_q] <= push_hw0_i;
      end
      if (!flush_i && push_cnt_i[1]) begin
         mem_q[tail_p1] <= push_hw1_i;
      end
   end

   assign count_o = count_q;
   assign peek0_o = mem_q[head_q];
   assign peek1_o = mem_q[head_p1];

endmodule

// File: rtl/fetch_realign_buf.sv
// Realigning fetch buffer: turns a stream of 32-bit fetch words into one whole
// instruction per cycle (16-bit or 32-bit), each tagged with its PC.
// Define CVA6_CEXT_EN to enable compressed-instruction support; without it every
// instruction is 32-bit and the PC steps by 4.
module fetch_realign_buf
   import fetch_realign_buf_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int HW_DEPTH = 8
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            fetch_valid_i,
   output logic            fetch_ready_o,
   input  logic [XLEN-1:0] fetch_data_i,
   input  logic [XLEN-1:0] fetch_addr_i,
   output logic            instr_valid_o,
   input  logic            instr_ready_i,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] instr_pc_o,
   output logic            instr_is_compressed_o
);

   localparam int CNT_W = $clog2(HW_DEPTH) + 1;
   // A whole word fits only while at least two slots are free.
   localparam logic [CNT_W-1:0] FREE_MIN_CNT = CNT_W'(HW_DEPTH - FETCH_HW_PER_WORD);

   fetch_req_t       req;
   realign_instr_t   out_instr;
   logic [CNT_W-1:0] count;
   logic [15:0]      hw0;
   logic [15:0]      hw1;
   logic [1:0]       push_cnt;
   logic [15:0]      push_hw0;
   logic [15:0]      push_hw1;
   logic [1:0]       pop_cnt;
   logic             push;
   logic             pop;
   logic             head_is_c;
   logic             head_valid;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic             pc_valid_q, pc_valid_d;
   logic             unused_addr_lsbs;

   assign req = '{data: fetch_data_i, addr: fetch_addr_i};
   // Byte offset bits are not needed by every build configuration.
   assign unused_addr_lsbs = ^req.addr[1:0];

   // Readiness depends only on registered occupancy, never on instr_ready_i.
   assign fetch_ready_o = !flush_i && (count <= FREE_MIN_CNT);
   assign push          = fetch_valid_i && fetch_ready_o;

   // Shape the accepted word into halfword pushes.
   always_comb begin
      push_cnt = 2'd0;
      push_hw0 = req.data[15:0];
      push_hw1 = req.data[31:16];
`ifdef CVA6_CEXT_EN
      if (push) begin
         if (req.addr[1]) begin
            // Fetch entered mid-word: the low halfword precedes the target PC.
            push_cnt = 2'd1;
            push_hw0 = req.data[31:16];
         end else begin
            push_cnt = 2'(FETCH_HW_PER_WORD);
         end
      end
`else
      if (push) begin
         push_cnt = 2'(FETCH_HW_PER_WORD);
      end
`endif
   end

   realign_hw_fifo #(
      .HW_DEPTH (HW_DEPTH)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .flush_i    (flush_i),
      .push_cnt_i (push_cnt),
      .push_hw0_i (push_hw0),
      .push_hw1_i (push_hw1),
      .pop_cnt_i  (pop_cnt),
      .count_o    (count),
      .peek0_o    (hw0),
      .peek1_o    (hw1)
   );

`ifdef CVA6_CEXT_EN
   assign head_is_c = hw_is_compressed(hw0[1:0]);
`else
   assign head_is_c = 1'b0;
`endif

   // A 32-bit head waits for its second halfword, which may arrive with the next word.
   assign head_valid = head_is_c ? (count != '0) : (count >= CNT_W'(2));
   assign pop        = head_valid && instr_ready_i;

   // Halfwords consumed by the decoder this cycle.
   always_comb begin
      pop_cnt = 2'd0;
      if (pop) begin
         pop_cnt = head_is_c ? 2'd1 : 2'd2;
      end
   end

   // Assemble the head instruction; all fields read zero when nothing is valid.
   always_comb begin
      out_instr = '0;
      if (head_valid) begin
         out_instr.instr         = head_is_c ? {16'h0000, hw0} : {hw1, hw0};
         out_instr.pc            = pc_q;
         out_instr.is_compressed = head_is_c;
      end
   end

   assign instr_valid_o         = head_valid;
   assign instr_o               = out_instr.instr;
   assign instr_pc_o            = out_instr.pc;
   assign instr_is_compressed_o = out_instr.is_compressed;

   // Head PC: captured from the first word after reset/flush, then advanced per pop.
   always_comb begin
      pc_d       = pc_q;
      pc_valid_d = pc_valid_q;
      if (flush_i) begin
         pc_valid_d = 1'b0;
      end else begin
         if (pop) begin
            pc_d = pc_q + (head_is_c ? XLEN'(2) : XLEN'(4));
         end
         // An empty buffer has no PC yet, so this never coincides with a pop.
         if (push && !pc_valid_q) begin
`ifdef CVA6_CEXT_EN
            pc_d = {req.addr[XLEN-1:1], 1'b0};
`else
            pc_d = {req.addr[XLEN-1:2], 2'b00};
`endif
            pc_valid_d = 1'b1;
         end
      end
   end

   // PC register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q       <= '0;
         pc_valid_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         pc_valid_q <= pc_valid_d;
      end
   end

endmodule

// File: tb/tb_fetch_realign_buf.sv
// Self-checking bench for fetch_realign_buf. The reference keeps the buffered
// halfwords in a queue and derives each cycle's outputs from the queue head.
module tb_fetch_realign_buf;

   localparam int HW_DEPTH = 8;
`ifdef CVA6_CEXT_EN
   localparam bit CEXT = 1'b1;
`else
   localparam bit CEXT = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i, flush_i, fetch_valid_i, instr_ready_i;
   logic [31:0] fetch_data_i, fetch_addr_i;
   logic        fetch_ready_o, instr_valid_o, instr_is_compressed_o;
   logic [31:0] instr_o, instr_pc_o;

   int total = 0;
   int bad   = 0;

   logic [15:0] hq[$];
   logic [31:0] mpc  = '0;
   bit          mpcv = 1'b0;

   typedef struct {
      logic        r, f, fv;
      logic [31:0] d, a;
      logic        rd;
      bit          lc;
      logic [66:0] lit;
   } cyc_t;

   logic [66:0] obs;
   assign obs = {fetch_ready_o, instr_valid_o, instr_is_compressed_o, instr_pc_o, instr_o};

   always #5 clk_i = ~clk_i;

   fetch_realign_buf #(.XLEN(32), .HW_DEPTH(HW_DEPTH)) dut (
      .clk_i                 (clk_i),
      .rst_i                 (rst_i),
      .flush_i               (flush_i),
      .fetch_valid_i         (fetch_valid_i),
      .fetch_ready_o         (fetch_ready_o),
      .fetch_data_i          (fetch_data_i),
      .fetch_addr_i          (fetch_addr_i),
      .instr_valid_o         (instr_valid_o),
      .instr_ready_i         (instr_ready_i),
      .instr_o               (instr_o),
      .instr_pc_o            (instr_pc_o),
      .instr_is_compressed_o (instr_is_compressed_o)
   );

   function automatic logic [66:0] ov(input logic rdy, vld, c, input logic [31:0] pc, ins);
      return {rdy, vld, c, pc, ins};
   endfunction

   function automatic cyc_t mk(input logic r, f, fv, input logic [31:0] d, a,
                               input logic rd, input bit lc, input logic [66:0] lit);
      cyc_t c;
      c.r = r; c.f = f; c.fv = fv; c.d = d; c.a = a; c.rd = rd; c.lc = lc; c.lit = lit;
      return c;
   endfunction

   function automatic bit m_is_c();
      if (!CEXT || hq.size() == 0) return 1'b0;
      return hq[0][1:0] != 2'b11;
   endfunction

   function automatic bit m_valid();
      if (hq.size() == 0) return 1'b0;
      if (m_is_c()) return 1'b1;
      return hq.size() >= 2;
   endfunction

   function automatic bit m_ready();
      return !flush_i && ((HW_DEPTH - hq.size()) >= 2);
   endfunction

   function automatic logic [66:0] m_exp();
      logic [31:0] ins;
      if (!m_valid()) return ov(m_ready(), 1'b0, 1'b0, 32'h0, 32'h0);
      ins = m_is_c() ? {16'h0000, hq[0]} : {hq[1], hq[0]};
      return ov(m_ready(), 1'b1, m_is_c(), mpc, ins);
   endfunction

   task automatic apply(input logic r, f, fv, input logic [31:0] d, a, input logic rd);
      @(negedge clk_i);
      rst_i = r; flush_i = f; fetch_valid_i = fv;
      fetch_data_i = d; fetch_addr_i = a; instr_ready_i = rd;
      #1;
   endtask

   // Advance the reference by one clock using the inputs currently applied.
   task automatic tick();
      bit c, v, acc;
      c   = m_is_c();
      v   = m_valid();
      acc = fetch_valid_i && m_ready();
      if (rst_i) begin
         hq.delete(); mpc = '0; mpcv = 1'b0;
      end else if (flush_i) begin
         hq.delete(); mpcv = 1'b0;
      end else begin
         if (v && instr_ready_i) begin
            void'(hq.pop_front());
            if (c) mpc = mpc + 32'd2;
            else begin
               void'(hq.pop_front());
               mpc = mpc + 32'd4;
            end
         end
         if (acc) begin
            if (CEXT && fetch_addr_i[1]) hq.push_back(fetch_data_i[31:16]);
            else begin
               hq.push_back(fetch_data_i[15:0]);
               hq.push_back(fetch_data_i[31:16]);
            end
            if (!mpcv) mpc = CEXT ? {fetch_addr_i[31:1], 1'b0} : {fetch_addr_i[31:2], 2'b00};
            mpcv = 1'b1;
         end
      end
      @(posedge clk_i);
   endtask

   task automatic test_reset();
      apply(1, 0, 0, 32'h0, 32'h0, 0);
      tick();
      apply(1, 0, 1, 32'h1234_5678, 32'h0, 1);
      total++;
      if (obs !== ov(1, 0, 0, 32'h0, 32'h0)) begin
         bad++; $display("FAIL reset_held got=%h want=%h", obs, ov(1, 0, 0, 32'h0, 32'h0));
      end
      tick();
      apply(0, 0, 0, 32'h0, 32'h0, 0);
      total++;
      if (obs !== ov(1, 0, 0, 32'h0, 32'h0)) begin
         bad++; $display("FAIL reset_release got=%h want=%h", obs, ov(1, 0, 0, 32'h0, 32'h0));
      end
      tick();
   endtask

   task automatic test_basic();
      cyc_t s[$];
      s.push_back(mk(0, 0, 1, 32'h0000_4501, 32'h8000_0000, 1, 1, ov(1, 0, 0, 0, 0)));
      s.push_back(mk(0, 0, 0, 0, 0, 1, 1, CEXT ? ov(1, 1, 1, 32'h8000_0000, 32'h0000_4501)
                                               : ov(1, 1, 0, 32'h8000_0000, 32'h0000_4501)));
      s.push_back(mk(0, 0, 0, 0, 0, 1, 1, CEXT ? ov(1, 1, 1, 32'h8000_0002, 32'h0)
                                               : ov(1, 0, 0, 0, 0)));
      s.push_back(mk(0, 0, 0, 0, 0, 1, 1, ov(1, 0, 0, 0, 0)));
      foreach (s[i]) begin
         apply(s[i].r, s[i].f, s[i].fv, s[i].d, s[i].a, s[i].rd);
         total++;
         if (obs !== m_exp()) begin
            bad++; $display("FAIL basic_model cyc=%0d got=%h want=%h", i, obs, m_exp());
         end
         if (s[i].lc) begin
            total++;
            if (obs !== s[i].lit) begin
               bad++; $display("FAIL basic_lit cyc=%0d got=%h want=%h", i, obs, s[i].lit);
            end
         end
         tick();
      end
   endtask

   task automatic test_straddle();
      cyc_t s[$];
      s.push_back(mk(0, 1, 0, 0, 0, 0, 0, '0));
      s.push_back(mk(0, 0, 1, 32'h0013_4501, 32'h100, 1, 1, ov(1, 0, 0, 0, 0)));
      s.push_back(mk(0, 0, 0, 0, 0, 1, 1, CEXT ? ov(1, 1, 1, 32'h100, 32'h4501)
                                               : ov(1, 1, 0, 32'h100, 32'h0013_4501)));
      s.push_back(mk(0, 0, 0, 0, 0, 1, 1, ov(1, 0, 0, 0, 0)));
      s.push_back(mk(0, 0, 1, 32'h0, 32'h104, 1, 1, ov(1, 0, 0, 0, 0)));
      s.push_back(mk(0, 0, 0, 0, 0, 1, 1, CEXT ? ov(1, 1, 0, 32'h102, 32'h13)
                                               : ov(1, 1, 0, 32'h104, 32'h0)));
      s.push_back(mk(0, 0, 0, 0, 0, 1, 1, CEXT ? ov(1, 1, 1, 32'h106, 32'h0)
                                               : ov(1, 0, 0, 0, 0)));
      s.push_back(mk(0, 0, 0, 0, 0, 1, 1, ov(1, 0, 0, 0, 0)));
      foreach (s[i]) begin
         apply(s[i].r, s[i].f, s[i].fv, s[i].d, s[i].a, s[i].rd);
         total++;
         if (obs !== m_exp()) begin
            bad++; $display("FAIL straddle_model cyc=%0d got=%h want=%h", i, obs, m_exp());
         end
         if (s[i].lc) begin
            total++;
            if (obs !== s[i].lit) begin
               bad++; $display("FAIL straddle_lit cyc=%0d got=%h want=%h", i, obs, s[i].lit);
            end
         end
         tick();
      end
   endtask

   task automatic test_misaligned();
      cyc_t s[$];
      s.push_back(mk(0, 1, 0, 0, 0, 0, 0, '0));
      s.push_back(mk(0, 0, 1, 32'h0001_1111, 32'h202, 1, 1, ov(1, 0, 0, 0, 0)));
      s.push_back(mk(0, 0, 0, 0, 0, 1, 1, CEXT ? ov(1, 1, 1, 32'h202, 32'h1)
                                               : ov(1, 1, 0, 32'h200, 32'h0001_1111)));
      s.push_back(mk(0, 0, 0, 0, 0, 1, 1, ov(1, 0, 0, 0, 0)));
      foreach (s[i]) begin
         apply(s[i].r, s[i].f, s[i].fv, s[i].d, s[i].a, s[i].rd);
         total++;
         if (obs !== m_exp()) begin
            bad++; $display("FAIL misaligned_model cyc=%0d got=%h want=%h", i, obs, m_exp());
         end
         if (s[i].lc) begin
            total++;
            if (obs !== s[i].lit) begin
               bad++; $display("FAIL misaligned_lit cyc=%0d got=%h want=%h", i, obs, s[i].lit);
            end
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      int k = 0;
      logic [31:0] d;
      apply(0, 1, 0, 0, 0, 0);
      total++;
      if (obs !== m_exp()) begin
         bad++; $display("FAIL bp_flush got=%h want=%h", obs, m_exp());
      end
      tick();
      for (int i = 0; i < 7; i++) begin
         d = {16'hA000 | 16'(k), 8'(k), 8'h03};
         apply(0, 0, 1, d, 32'(4 * k), 0);
         total++;
         if (obs !== m_exp()) begin
            bad++; $display("FAIL bp_fill_model cyc=%0d got=%h want=%h", i, obs, m_exp());
         end
         total++;
         if (i == 0) begin
            if (obs !== ov(1, 0, 0, 0, 0)) begin
               bad++; $display("FAIL bp_fill_lit cyc=%0d got=%h want=%h", i, obs, ov(1, 0, 0, 0, 0));
            end
         end else if (obs !== ov(i < 4, 1, 0, 32'h0, 32'hA000_0003)) begin
            bad++; $display("FAIL bp_fill_lit cyc=%0d got=%h want=%h", i, obs,
                            ov(i < 4, 1, 0, 32'h0, 32'hA000_0003));
         end
         if (m_ready()) k++;
         tick();
      end
      for (int j = 0; j < 6; j++) begin
         apply(0, 0, 0, 0, 0, 1);
         total++;
         if (obs !== m_exp()) begin
            bad++; $display("FAIL bp_drain_model cyc=%0d got=%h want=%h", j, obs, m_exp());
         end
         if (j < 4) begin
            d = {16'hA000 | 16'(j), 8'(j), 8'h03};
            total++;
            if (obs !== ov(j > 0, 1, 0, 32'(4 * j), d)) begin
               bad++; $display("FAIL bp_drain_lit cyc=%0d got=%h want=%h", j, obs,
                               ov(j > 0, 1, 0, 32'(4 * j), d));
            end
         end
         tick();
      end
   endtask

   task automatic test_flush();
      cyc_t s[$];
      s.push_back(mk(0, 1, 0, 0, 0, 0, 0, '0));
      s.push_back(mk(0, 0, 1, 32'h0013_4501, 32'h100, 1, 1, ov(1, 0, 0, 0, 0)));
      s.push_back(mk(0, 0, 0, 0, 0, 1, 1, CEXT ? ov(1, 1, 1, 32'h100, 32'h4501)
                                               : ov(1, 1, 0, 32'h100, 32'h0013_4501)));
      s.push_back(mk(0, 1, 1, 32'h0, 32'h104, 1, 1, ov(0, 0, 0, 0, 0)));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 1, ov(1, 0, 0, 0, 0)));
      s.push_back(mk(0, 0, 1, 32'h0000_0001, 32'h400, 0, 1, ov(1, 0, 0, 0, 0)));
      s.push_back(mk(0, 0, 0, 0, 0, 0, 1, CEXT ? ov(1, 1, 1, 32'h400, 32'h1)
                                               : ov(1, 1, 0, 32'h400, 32'h1)));
      s.push_back(mk(0, 0, 0, 0, 0, 1, 1, CEXT ? ov(1, 1, 1, 32'h400, 32'h1)
                                               : ov(1, 1, 0, 32'h400, 32'h1)));
      s.push_back(mk(0, 0, 0, 0, 0, 1, 1, CEXT ? ov(1, 1, 1, 32'h402, 32'h0)
                                               : ov(1, 0, 0, 0, 0)));
      s.push_back(mk(0, 0, 0, 0, 0, 1, 1, ov(1, 0, 0, 0, 0)));
      foreach (s[i]) begin
         apply(s[i].r, s[i].f, s[i].fv, s[i].d, s[i].a, s[i].rd);
         total++;
         if (obs !== m_exp()) begin
            bad++; $display("FAIL flush_model cyc=%0d got=%h want=%h", i, obs, m_exp());
         end
         if (s[i].lc) begin
            total++;
            if (obs !== s[i].lit) begin
               bad++; $display("FAIL flush_lit cyc=%0d got=%h want=%h", i, obs, s[i].lit);
            end
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      cyc_t s[$];
      s.push_back(mk(0, 1, 0, 0, 0, 0, 0, '0));
      s.push_back(mk(0, 0, 1, 32'h2222_1111, 32'h302, 0, 0, '0));
      s.push_back(mk(0, 0, 1, 32'h4444_3333, 32'h304, 0, 0, '0));
      s.push_back(mk(0, 0, 1, 32'h6666_5555, 32'h308, 0, 0, '0));
      s.push_back(mk(1, 0, 1, 32'h7777_7777, 32'h30C, 1, 1, CEXT ? ov(1, 1, 1, 32'h302, 32'h2222)
                                                                : ov(1, 1, 0, 32'h300, 32'h2222_1111)));
      s.push_back(mk(0, 0, 0, 0, 0, 1, 1, ov(1, 0, 0, 0, 0)));
      s.push_back(mk(0, 0, 1, 32'h0000_0001, 32'h500, 1, 1, ov(1, 0, 0, 0, 0)));
      s.push_back(mk(0, 0, 0, 0, 0, 1, 1, CEXT ? ov(1, 1, 1, 32'h500, 32'h1)
                                               : ov(1, 1, 0, 32'h500, 32'h1)));
      s.push_back(mk(0, 0, 0, 0, 0, 1, 0, '0));
      s.push_back(mk(0, 0, 0, 0, 0, 1, 0, '0));
      foreach (s[i]) begin
         apply(s[i].r, s[i].f, s[i].fv, s[i].d, s[i].a, s[i].rd);
         total++;
         if (obs !== m_exp()) begin
            bad++; $display("FAIL reset_mid_model cyc=%0d got=%h want=%h", i, obs, m_exp());
         end
         if (s[i].lc) begin
            total++;
            if (obs !== s[i].lit) begin
               bad++; $display("FAIL reset_mid_lit cyc=%0d got=%h want=%h", i, obs, s[i].lit);
            end
         end
         tick();
      end
   endtask

   task automatic test_wrap();
      int k = 0;
      int e = 0;
      logic [66:0] want;
      apply(0, 1, 0, 0, 0, 0);
      tick();
      for (int i = 0; i < 28; i++) begin
         apply(0, 0, k < 10, {16'((((2 * k) + 1) << 2) | 1), 16'(((2 * k) << 2) | 1)},
               32'h600 + 32'(4 * k), 1);
         total++;
         if (obs !== m_exp()) begin
            bad++; $display("FAIL wrap_model cyc=%0d got=%h want=%h", i, obs, m_exp());
         end
         if (m_valid()) begin
            want = CEXT ? ov(m_ready(), 1, 1, 32'h600 + 32'(2 * e), 32'((e << 2) | 1))
                        : ov(m_ready(), 1, 0, 32'h600 + 32'(4 * e),
                             {16'((((2 * e) + 1) << 2) | 1), 16'(((2 * e) << 2) | 1)});
            total++;
            if (obs !== want) begin
               bad++; $display("FAIL wrap_seq n=%0d got=%h want=%h", e, obs, want);
            end
            e++;
         end
         if (k < 10 && m_ready()) k++;
         tick();
      end
   endtask

   task automatic test_random();
      logic [31:0] next_a;
      logic [31:0] tmp;
      logic        r, f, fv, rd;
      bit          acc;
      apply(0, 1, 0, 0, 0, 0);
      tick();
      next_a = CEXT ? 32'hFFFF_FFF6 : 32'hFFFF_FFF8;
      for (int i = 0; i < 400; i++) begin
         r  = ($urandom_range(0, 99) == 0);
         f  = ($urandom_range(0, 39) == 0);
         fv = ($urandom_range(0, 3) != 0);
         rd = ($urandom_range(0, 3) != 0);
         tmp = $urandom;
         apply(r, f, fv, tmp, next_a, rd);
         total++;
         if (obs !== m_exp()) begin
            bad++; $display("FAIL random_model cyc=%0d got=%h want=%h", i, obs, m_exp());
         end
         acc = fv && m_ready() && !r;
         tick();
         if (r || f) begin
            tmp = $urandom;
            next_a = CEXT ? (tmp & 32'hFFFF_FFFE) : (tmp & 32'hFFFF_FFFC);
         end else if (acc) begin
            next_a = {next_a[31:2] + 30'd1, 2'b00};
         end
      end
   endtask

   initial begin
      rst_i = 1'b1; flush_i = 1'b0; fetch_valid_i = 1'b0; instr_ready_i = 1'b0;
      fetch_data_i = '0; fetch_addr_i = '0;
      test_reset();
      test_basic();
      test_straddle();
      test_misaligned();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
